res_wr_arb: RTL and testbench

// - Writer side of the checker write interface: collects signed results from the xb and fir engines,

---
 rtl/res_wr_pkg.sv | 17 +
 rtl/res_wr_arb_if.sv | 38 +++
 rtl/res_fifo.sv | 55 +++++
 rtl/res_wr_arb.sv | 116 +++++++++++
 tb/tb_res_wr_arb.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/res_wr_pkg.sv
// Shared types and helpers for the result write arbiter: source identifiers and
// FIFO pointer sizing.
package res_wr_pkg;

    localparam int DW_DEF = 16;

    typedef enum logic {
        SRC_XB  = 1'b0,
        SRC_FIR = 1'b1
    } src_e;

    // One extra pointer bit distinguishes full from empty when the address bits match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/res_wr_arb_if.sv
// Bundle of engine-side result handshakes, checker-side write strobes and the
// control/status lines of the result write arbiter.
interface res_wr_arb_if
    import res_wr_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic          flush;
    logic          ovf_clr;
    logic          xb_res_valid;
    logic [DW-1:0] xb_res_data;
    logic          xb_res_ready;
    logic          fir_res_valid;
    logic [DW-1:0] fir_res_data;
    logic          fir_res_ready;
    logic          xb_write_req;
    logic [DW-1:0] xb_write_data;
    logic          fir_write_req;
    logic [DW-1:0] fir_write_data;
    logic          xb_ovf;
    logic          fir_ovf;

    modport master (
        output flush, ovf_clr,
        output xb_res_valid, xb_res_data, fir_res_valid, fir_res_data,
        input  xb_res_ready, fir_res_ready,
        input  xb_write_req, xb_write_data, fir_write_req, fir_write_data,
        input  xb_ovf, fir_ovf
    );

    modport slave (
        input  flush, ovf_clr,
        input  xb_res_valid, xb_res_data, fir_res_valid, fir_res_data,
        output xb_res_ready, fir_res_ready,
        output xb_write_req, xb_write_data, fir_write_req, fir_write_data,
        output xb_ovf, fir_ovf
    );
endinterface

// File: rtl/res_fifo.sv
// Small synchronous FIFO for one result stream; head is read straight from the
// storage array so the consumer can register it on the pop edge.
module res_fifo
    import res_wr_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [DW-1:0] mem [DEPTH];
    logic          push_en;
    logic          pop_en;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A flush cycle neither accepts nor releases data.
    assign push_en = push && !full && !flush;
    assign pop_en  = pop && !empty && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_en) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop_en)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign head = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/res_wr_arb.sv
// Round-robin writer toward the checker: one FIFO per engine, at most one write
// pulse per cycle, optional idle spacing after each write, sticky overflow flags.
module res_wr_arb
    import res_wr_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input logic         clk,
    input logic         reset,
    res_wr_arb_if.slave bus
);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    logic [1:0]    res_valid;
    logic [DW-1:0] res_data [2];
    logic [1:0]    fifo_full;
    logic [1:0]    fifo_empty;
    logic [DW-1:0] head [2];
    logic [1:0]    grant;
    logic          grant_any;
    src_e          grant_src;
    src_e          last_grant_reg;
    logic [GW-1:0] gap_cnt_reg;

    assign res_valid[SRC_XB]  = bus.xb_res_valid;
    assign res_valid[SRC_FIR] = bus.fir_res_valid;
    assign res_data[SRC_XB]   = bus.xb_res_data;
    assign res_data[SRC_FIR]  = bus.fir_res_data;

    // On a tie the source that did not win last time is served.
    always_comb begin
        grant_any = 1'b0;
        grant_src = SRC_XB;
        if (gap_cnt_reg == '0 && !bus.flush) begin
            if (!fifo_empty[SRC_XB] && !fifo_empty[SRC_FIR]) begin
                grant_any = 1'b1;
                grant_src = (last_grant_reg == SRC_XB) ? SRC_FIR : SRC_XB;
            end else if (!fifo_empty[SRC_XB]) begin
                grant_any = 1'b1;
                grant_src = SRC_XB;
            end else if (!fifo_empty[SRC_FIR]) begin
                grant_any = 1'b1;
                grant_src = SRC_FIR;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic          write_req_reg;
        logic [DW-1:0] write_data_reg;
        logic          ovf_reg;

        assign grant[gi] = grant_any && (grant_src == src_e'(gi));

        res_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .flush     (bus.flush),
            .push      (res_valid[gi]),
            .push_data (res_data[gi]),
            .pop       (grant[gi]),
            .full      (fifo_full[gi]),
            .empty     (fifo_empty[gi]),
            .head      (head[gi])
        );

        // Data bus is forced to zero when idle because the checker ORs both buses.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                write_req_reg  <= 1'b0;
                write_data_reg <= '0;
            end else begin
                write_req_reg  <= grant[gi];
                write_data_reg <= grant[gi] ? head[gi] : '0;
            end
        end

        // Setting outranks clearing so a drop in the clear cycle is never lost.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ovf_reg <= 1'b0;
            end else if (res_valid[gi] && fifo_full[gi] && !bus.flush) begin
                ovf_reg <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_reg <= SRC_FIR;
            gap_cnt_reg    <= '0;
        end else begin
            if (grant_any) last_grant_reg <= grant_src;
            if (bus.flush)                gap_cnt_reg <= '0;
            else if (grant_any)           gap_cnt_reg <= GW'(GAP);
            else if (gap_cnt_reg != '0)   gap_cnt_reg <= gap_cnt_reg - GW'(1);
        end
    end

    assign bus.xb_res_ready   = !fifo_full[SRC_XB];
    assign bus.fir_res_ready  = !fifo_full[SRC_FIR];
    assign bus.xb_write_req   = g_src[0].write_req_reg;
    assign bus.xb_write_data  = g_src[0].write_data_reg;
    assign bus.fir_write_req  = g_src[1].write_req_reg;
    assign bus.fir_write_data = g_src[1].write_data_reg;
    assign bus.xb_ovf         = g_src[0].ovf_reg;
    assign bus.fir_ovf        = g_src[1].ovf_reg;

endmodule

// File: tb/tb_res_wr_arb.sv
// Directed bench for res_wr_arb: a vector table for the dual-source arbitration
// run, plus hand sequences for latency, spacing, overflow, flush and reset.
module tb_res_wr_arb;
    import res_wr_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    res_wr_arb_if #(.DW(16)) bus0 ();
    res_wr_arb_if #(.DW(16)) bus1 ();

    res_wr_arb #(.DW(16), .DEPTH(4), .GAP(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    res_wr_arb #(.DW(16), .DEPTH(4), .GAP(3)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write log of the spaced instance, stamped with the cycle count.
    logic [15:0] wq[$];
    int          tq[$];
    always @(negedge clk) begin
        if (bus1.xb_write_req) begin
            wq.push_back(bus1.xb_write_data);
            tq.push_back(cyc);
        end
        chk("one_req_dut0", {31'd0, bus0.xb_write_req & bus0.fir_write_req}, 32'd0);
        chk("one_req_dut1", {31'd0, bus1.xb_write_req & bus1.fir_write_req}, 32'd0);
    end

    typedef struct packed {
        logic        xv;
        logic [15:0] xd;
        logic        fv;
        logic [15:0] fd;
        logic        clr;
        logic        exq;
        logic [15:0] exd;
        logic        efq;
        logic [15:0] efd;
        logic        exr;
        logic        efr;
        logic        exo;
        logic        efo;
    } vec_t;

    vec_t tbl [17];

    task automatic idle_inputs();
        bus0.xb_res_valid = 0; bus0.xb_res_data = '0; bus0.fir_res_valid = 0; bus0.fir_res_data = '0;
        bus0.flush = 0; bus0.ovf_clr = 0;
        bus1.xb_res_valid = 0; bus1.xb_res_data = '0; bus1.fir_res_valid = 0; bus1.fir_res_data = '0;
        bus1.flush = 0; bus1.ovf_clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wq.delete();
        tq.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();

        // Both sources every cycle for 8 cycles, then drain and clear ovf.
        tbl[0]  = '{1, 16'h1000, 1, 16'h2000, 0,  0, 16'h0000, 0, 16'h0000,  1, 1, 0, 0};
        tbl[1]  = '{1, 16'h1001, 1, 16'h2001, 0,  1, 16'h1000, 0, 16'h0000,  1, 1, 0, 0};
        tbl[2]  = '{1, 16'h1002, 1, 16'h2002, 0,  0, 16'h0000, 1, 16'h2000,  1, 1, 0, 0};
        tbl[3]  = '{1, 16'h1003, 1, 16'h2003, 0,  1, 16'h1001, 0, 16'h0000,  1, 1, 0, 0};
        tbl[4]  = '{1, 16'h1004, 1, 16'h2004, 0,  0, 16'h0000, 1, 16'h2001,  1, 1, 0, 0};
        tbl[5]  = '{1, 16'h1005, 1, 16'h2005, 0,  1, 16'h1002, 0, 16'h0000,  1, 0, 0, 0};
        tbl[6]  = '{1, 16'h1006, 1, 16'h2006, 0,  0, 16'h0000, 1, 16'h2002,  0, 1, 0, 1};
        tbl[7]  = '{1, 16'h1007, 1, 16'h2007, 0,  1, 16'h1003, 0, 16'h0000,  1, 0, 1, 1};
        tbl[8]  = '{0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 1, 16'h2003,  1, 1, 1, 1};
        tbl[9]  = '{0, 16'h0000, 0, 16'h0000, 0,  1, 16'h1004, 0, 16'h0000,  1, 1, 1, 1};
        tbl[10] = '{0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 1, 16'h2004,  1, 1, 1, 1};
        tbl[11] = '{0, 16'h0000, 0, 16'h0000, 0,  1, 16'h1005, 0, 16'h0000,  1, 1, 1, 1};
        tbl[12] = '{0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 1, 16'h2005,  1, 1, 1, 1};
        tbl[13] = '{0, 16'h0000, 0, 16'h0000, 0,  1, 16'h1006, 0, 16'h0000,  1, 1, 1, 1};
        tbl[14] = '{0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 1, 16'h2007,  1, 1, 1, 1};
        tbl[15] = '{0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 0, 16'h0000,  1, 1, 1, 1};
        tbl[16] = '{0, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0000,  1, 1, 0, 0};

        do_reset();
        chk("rst_xb_req",  {31'd0, bus0.xb_write_req}, 32'd0);
        chk("rst_fir_req", {31'd0, bus0.fir_write_req}, 32'd0);
        chk("rst_xb_data", {16'd0, bus0.xb_write_data}, 32'd0);
        chk("rst_ready",   {30'd0, bus0.xb_res_ready, bus0.fir_res_ready}, 32'd3);
        chk("rst_ovf",     {30'd0, bus0.xb_ovf, bus0.fir_ovf}, 32'd0);

        for (int i = 0; i < 17; i++) begin
            bus0.xb_res_valid  = tbl[i].xv;
            bus0.xb_res_data   = tbl[i].xd;
            bus0.fir_res_valid = tbl[i].fv;
            bus0.fir_res_data  = tbl[i].fd;
            bus0.ovf_clr       = tbl[i].clr;
            step();
            $display("vec %0d: xb_req=%0d xb_data=%h fir_req=%0d fir_data=%h rdy=%0d%0d ovf=%0d%0d", i,
                     bus0.xb_write_req, bus0.xb_write_data, bus0.fir_write_req, bus0.fir_write_data,
                     bus0.xb_res_ready, bus0.fir_res_ready, bus0.xb_ovf, bus0.fir_ovf);
            chk($sformatf("vec%0d_xb_req", i),   {31'd0, bus0.xb_write_req}, {31'd0, tbl[i].exq});
            chk($sformatf("vec%0d_xb_data", i),  {16'd0, bus0.xb_write_data}, {16'd0, tbl[i].exd});
            chk($sformatf("vec%0d_fir_req", i),  {31'd0, bus0.fir_write_req}, {31'd0, tbl[i].efq});
            chk($sformatf("vec%0d_fir_data", i), {16'd0, bus0.fir_write_data}, {16'd0, tbl[i].efd});
            chk($sformatf("vec%0d_ready", i), {30'd0, bus0.xb_res_ready, bus0.fir_res_ready},
                {30'd0, tbl[i].exr, tbl[i].efr});
            chk($sformatf("vec%0d_ovf", i), {30'd0, bus0.xb_ovf, bus0.fir_ovf},
                {30'd0, tbl[i].exo, tbl[i].efo});
        end
        idle_inputs();

        // Single negative sample: written two edges after it is driven.
        do_reset();
        bus0.xb_res_valid = 1; bus0.xb_res_data = 16'hFFF6;
        step();
        chk("single_early", {31'd0, bus0.xb_write_req}, 32'd0);
        bus0.xb_res_valid = 0; bus0.xb_res_data = '0;
        step();
        $display("single: xb_req=%0d data=%h fir_req=%0d", bus0.xb_write_req, bus0.xb_write_data, bus0.fir_write_req);
        chk("single_req",  {31'd0, bus0.xb_write_req}, 32'd1);
        chk("single_data", {16'd0, bus0.xb_write_data}, 32'h0000FFF6);
        chk("single_fir",  {31'd0, bus0.fir_write_req}, 32'd0);
        begin
            int extra = 0;
            for (int k = 0; k < 5; k++) begin
                step();
                extra += int'(bus0.xb_write_req) + int'(bus0.fir_write_req);
            end
            chk("single_once", extra, 32'd0);
            chk("single_idle_data", {16'd0, bus0.xb_write_data}, 32'd0);
        end

        // GAP=3: four queued samples appear four cycles apart.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus1.xb_res_valid = 1; bus1.xb_res_data = 16'hA000 + 16'(k);
            step();
        end
        idle_inputs();
        repeat (20) step();
        $display("gap: writes=%0d", wq.size());
        chk("gap_count", wq.size(), 32'd4);
        for (int k = 0; k < wq.size() && k < 4; k++) begin
            chk($sformatf("gap_data%0d", k), {16'd0, wq[k]}, 32'hA000 + k);
            if (k > 0) chk($sformatf("gap_space%0d", k), tq[k] - tq[k-1], 32'd4);
        end

        // Overflow: hold xb valid into a full FIFO, then exercise ovf_clr.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            bus1.xb_res_valid = 1; bus1.xb_res_data = 16'hB000 + 16'(k);
            step();
            if (k == 4) chk("ovf_ready_low", {31'd0, bus1.xb_res_ready}, 32'd0);
            if (k == 3) chk("ovf_not_yet", {31'd0, bus1.xb_ovf}, 32'd0);
        end
        $display("ovf: xb_ovf=%0d after hold", bus1.xb_ovf);
        chk("ovf_set", {31'd0, bus1.xb_ovf}, 32'd1);
        bus1.xb_res_data = 16'hBEEF; bus1.ovf_clr = 1;
        step();
        chk("ovf_set_wins", {31'd0, bus1.xb_ovf}, 32'd1);
        bus1.xb_res_valid = 0; bus1.xb_res_data = '0;
        step();
        chk("ovf_cleared", {31'd0, bus1.xb_ovf}, 32'd0);
        idle_inputs();
        repeat (30) step();
        begin
            logic [15:0] exp_q [6];
            exp_q = '{16'hB000, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hB006};
            $display("ovf: writes=%0d", wq.size());
            chk("ovf_wr_count", wq.size(), 32'd6);
            for (int k = 0; k < 6 && k < wq.size(); k++)
                chk($sformatf("ovf_wr%0d", k), {16'd0, wq[k]}, {16'd0, exp_q[k]});
        end

        // Flush with three samples queued; a push in the flush cycle is discarded.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus1.xb_res_valid = 1; bus1.xb_res_data = 16'hC000 + 16'(k);
            step();
        end
        bus1.xb_res_data = 16'hDEAD; bus1.flush = 1;
        step();
        idle_inputs();
        chk("flush_ready", {31'd0, bus1.xb_res_ready}, 32'd1);
        chk("flush_no_ovf", {31'd0, bus1.xb_ovf}, 32'd0);
        repeat (10) step();
        $display("flush: writes=%0d", wq.size());
        chk("flush_writes", wq.size(), 32'd1);
        bus1.xb_res_valid = 1; bus1.xb_res_data = 16'h5A5A;
        step();
        idle_inputs();
        repeat (3) step();
        chk("flush_after_cnt", wq.size(), 32'd2);
        if (wq.size() == 2) chk("flush_after_data", {16'd0, wq[1]}, 32'h00005A5A);

        // Asynchronous reset during a write pulse, then tie goes to xb.
        do_reset();
        bus0.xb_res_valid = 1; bus0.xb_res_data = 16'h1111;
        bus0.fir_res_valid = 1; bus0.fir_res_data = 16'h2222;
        step();
        idle_inputs();
        step();
        chk("arst_req_before", {31'd0, bus0.xb_write_req}, 32'd1);
        reset = 1'b1;
        #1;
        $display("arst: xb_req=%0d data=%h without edge", bus0.xb_write_req, bus0.xb_write_data);
        chk("arst_req_drop", {31'd0, bus0.xb_write_req}, 32'd0);
        chk("arst_data_drop", {16'd0, bus0.xb_write_data}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        begin
            int stray = 0;
            for (int k = 0; k < 3; k++) begin
                step();
                stray += int'(bus0.xb_write_req) + int'(bus0.fir_write_req);
            end
            chk("arst_empty", stray, 32'd0);
        end
        bus0.xb_res_valid = 1; bus0.xb_res_data = 16'h3333;
        bus0.fir_res_valid = 1; bus0.fir_res_data = 16'h4444;
        step();
        idle_inputs();
        step();
        chk("arst_tie_xb", {31'd0, bus0.xb_write_req}, 32'd1);
        chk("arst_tie_data", {16'd0, bus0.xb_write_data}, 32'h00003333);
        step();
        chk("arst_then_fir", {31'd0, bus0.fir_write_req}, 32'd1);
        chk("arst_fir_data", {16'd0, bus0.fir_write_data}, 32'h00004444);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
